// File: rtl/core_s2_branch_resolver_if.sv
// core_s2_branch_resolver_if: stage-2 branch inputs, fetch redirect handshake and stat outputs
interface core_s2_branch_resolver_if;
   logic        s2_valid;
   logic        s2_is_branch;
   logic        s2_is_jump;
   logic [31:0] s2_target;
   logic        cmp_result;
   logic        flush;
   logic        redirect_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        s2_stall;
   logic        kill_younger;
   logic        misaligned;
   logic [31:0] stat_resolved;
   logic [31:0] stat_taken;
   modport master (
      output s2_valid, s2_is_branch, s2_is_jump, s2_target, cmp_result, flush, redirect_ready,
      input  redirect_valid, redirect_pc, s2_stall, kill_younger, misaligned, stat_resolved, stat_taken
   );
   modport slave (
      input  s2_valid, s2_is_branch, s2_is_jump, s2_target, cmp_result, flush, redirect_ready,
      output redirect_valid, redirect_pc, s2_stall, kill_younger, misaligned, stat_resolved, stat_taken
   );
endinterface

// File: rtl/core_s2_branch_resolver.sv
// core_s2_branch_resolver: stage-2 taken branch/jump -> fetch redirect; LETC_BRANCH_STATS_EN adds counters
module core_s2_branch_resolver (
   input logic clk,
   input logic rst_n,
   core_s2_branch_resolver_if.slave bus
);
   typedef enum logic {IDLE, PENDING} state_t;
   state_t      state;
   logic        kill_q, mis_q, taken, aligned, hs;
   logic [31:0] pc_q;
   assign bus.s2_stall       = state == PENDING;
   assign taken              = bus.s2_valid & ~bus.s2_stall & ~bus.flush &
                               (bus.s2_is_jump | (bus.s2_is_branch & bus.cmp_result));
   assign aligned            = bus.s2_target[1:0] == 2'b00;
   assign bus.redirect_valid = bus.s2_stall & ~bus.flush;
   assign bus.redirect_pc    = pc_q;
   assign hs                 = bus.redirect_valid & bus.redirect_ready;
   assign bus.kill_younger   = kill_q & ~bus.flush;
   assign bus.misaligned     = mis_q & ~bus.flush;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc_q   <= '0;
         kill_q <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         kill_q <= taken & aligned;
         mis_q  <= taken & ~aligned;
         if (taken & aligned) pc_q <= bus.s2_target;
         state  <= (state == IDLE) ? ((taken & aligned) ? PENDING : IDLE)
                                   : ((bus.flush | hs) ? IDLE : PENDING);
      end
   end
`ifdef LETC_BRANCH_STATS_EN
   logic        acc;
   logic [31:0] res_q, tak_q;
   assign acc = bus.s2_valid & ~bus.s2_stall & ~bus.flush & (bus.s2_is_branch | bus.s2_is_jump);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q <= '0;
         tak_q <= '0;
      end else begin
         res_q <= res_q + 32'(acc);
         tak_q <= tak_q + 32'(hs);
      end
   end
   assign bus.stat_resolved = res_q;
   assign bus.stat_taken    = tak_q;
`else
   assign bus.stat_resolved = '0;
   assign bus.stat_taken    = '0;
`endif
endmodule

// File: tb/tb_core_s2_branch_resolver.sv
// tb_core_s2_branch_resolver: directed vectors with hand-computed expectations
module tb_core_s2_branch_resolver;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_res = 0;
   int   exp_tak = 0;
   core_s2_branch_resolver_if bus();
   core_s2_branch_resolver dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic br, input logic jp, input logic [31:0] tgt,
                        input logic cmp, input logic fl, input logic rdy);
      bus.s2_valid       = v;
      bus.s2_is_branch   = br;
      bus.s2_is_jump     = jp;
      bus.s2_target      = tgt;
      bus.cmp_result     = cmp;
      bus.flush          = fl;
      bus.redirect_ready = rdy;
      #2;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_stats(input string tag);
`ifdef LETC_BRANCH_STATS_EN
      chk({tag, "_res"}, bus.stat_resolved, 32'(exp_res));
      chk({tag, "_tak"}, bus.stat_taken, 32'(exp_tak));
`else
      chk({tag, "_res"}, bus.stat_resolved, 32'd0);
      chk({tag, "_tak"}, bus.stat_taken, 32'd0);
`endif
   endtask
   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      tick();
      tick();
      chk("rst_rv", 32'(bus.redirect_valid), 0);
      chk("rst_stall", 32'(bus.s2_stall), 0);
      chk("rst_pc", bus.redirect_pc, 0);
      chk("rst_kill", 32'(bus.kill_younger), 0);
      chk("rst_mis", 32'(bus.misaligned), 0);
      chk_stats("rst");
      rst_n = 1'b1;
      // BEQ taken, fetch always ready
      drive(1, 1, 0, 32'h0000_1000, 1, 0, 1);
      chk("beq_same_rv", 32'(bus.redirect_valid), 0);
      chk("beq_same_stall", 32'(bus.s2_stall), 0);
      tick();
      exp_res++;
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("beq_rv", 32'(bus.redirect_valid), 1);
      chk("beq_pc", bus.redirect_pc, 32'h1000);
      chk("beq_kill", 32'(bus.kill_younger), 1);
      chk("beq_stall", 32'(bus.s2_stall), 1);
      chk("beq_mis", 32'(bus.misaligned), 0);
      tick();
      exp_tak++;
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("beq_after_rv", 32'(bus.redirect_valid), 0);
      chk("beq_after_stall", 32'(bus.s2_stall), 0);
      chk("beq_after_kill", 32'(bus.kill_younger), 0);
      chk_stats("beq");
      // JAL with fetch back-pressure for three cycles; new valid s2 inputs must be ignored while stalled
      drive(1, 0, 1, 32'h0000_2000, 0, 0, 0);
      tick();
      exp_res++;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, 32'h0000_5000, 0, 0, i == 3);
         chk($sformatf("jal_rv%0d", i), 32'(bus.redirect_valid), 1);
         chk($sformatf("jal_stall%0d", i), 32'(bus.s2_stall), 1);
         chk($sformatf("jal_pc%0d", i), bus.redirect_pc, 32'h2000);
         chk($sformatf("jal_kill%0d", i), 32'(bus.kill_younger), 32'(i == 0));
         tick();
      end
      exp_tak++;
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      chk("jal_after_rv", 32'(bus.redirect_valid), 0);
      chk("jal_after_stall", 32'(bus.s2_stall), 0);
      chk_stats("jal");
      // BNE not taken
      drive(1, 1, 0, 32'h0000_3000, 0, 0, 1);
      tick();
      exp_res++;
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("bne_rv", 32'(bus.redirect_valid), 0);
      chk("bne_stall", 32'(bus.s2_stall), 0);
      chk("bne_kill", 32'(bus.kill_younger), 0);
      chk("bne_mis", 32'(bus.misaligned), 0);
      chk_stats("bne");
      // Misaligned taken target
      drive(1, 1, 0, 32'h0000_1002, 1, 0, 1);
      tick();
      exp_res++;
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("mis_pulse", 32'(bus.misaligned), 1);
      chk("mis_rv", 32'(bus.redirect_valid), 0);
      chk("mis_stall", 32'(bus.s2_stall), 0);
      chk("mis_kill", 32'(bus.kill_younger), 0);
      tick();
      chk("mis_once", 32'(bus.misaligned), 0);
      chk("mis_idle_rv", 32'(bus.redirect_valid), 0);
      chk_stats("mis");
      // Misaligned pulse masked by flush
      drive(1, 0, 1, 32'h0000_0001, 0, 0, 1);
      tick();
      exp_res++;
      drive(0, 0, 0, 32'h0, 0, 1, 1);
      chk("mis_flush", 32'(bus.misaligned), 0);
      tick();
      // Flush and ready together in PENDING
      drive(1, 1, 0, 32'h0000_3000, 1, 0, 1);
      tick();
      exp_res++;
      drive(0, 0, 0, 32'h0, 0, 1, 1);
      chk("fl_rv", 32'(bus.redirect_valid), 0);
      chk("fl_kill", 32'(bus.kill_younger), 0);
      chk("fl_stall", 32'(bus.s2_stall), 1);
      tick();
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("fl_after_rv", 32'(bus.redirect_valid), 0);
      chk("fl_after_stall", 32'(bus.s2_stall), 0);
      chk("fl_hold_pc", bus.redirect_pc, 32'h3000);
      chk_stats("fl");
      // Flush in IDLE blocks capture
      drive(1, 0, 1, 32'h0000_6000, 0, 1, 1);
      tick();
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("fli_rv", 32'(bus.redirect_valid), 0);
      chk("fli_stall", 32'(bus.s2_stall), 0);
      chk("fli_kill", 32'(bus.kill_younger), 0);
      chk("fli_pc", bus.redirect_pc, 32'h3000);
      chk_stats("fli");
      // Reset during PENDING, with flush and ready also high
      drive(1, 0, 1, 32'h0000_4000, 0, 0, 0);
      tick();
      drive(0, 0, 0, 32'h0, 0, 1, 1);
      chk("rp_pending", 32'(bus.s2_stall), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_res = 0;
      exp_tak = 0;
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      chk("rp_rv", 32'(bus.redirect_valid), 0);
      chk("rp_stall", 32'(bus.s2_stall), 0);
      chk("rp_pc", bus.redirect_pc, 0);
      chk("rp_kill", 32'(bus.kill_younger), 0);
      chk_stats("rp");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/core_s2_branch_resolver.md
CORE_S2_BRANCH_RESOLVER -- requirements
Module: core_s2_branch_resolver

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-003 s2_valid  input  1  instruction in stage 2 is valid this cycle.
REQ-004 s2_is_branch  input  1  s2 instruction is a conditional branch (BEQ..BGEU).
REQ-005 s2_is_jump  input  1  s2 instruction is JAL/JALR (unconditionally taken).
REQ-006 s2_target  input  32 (word_t)  computed branch/jump target.
REQ-007 cmp_result  input  1  stage-2 comparator outcome; 1 = condition true.
REQ-008 flush  input  1  trap/higher-priority redirect; cancels any pending redirect.
REQ-009 redirect_ready  input  1  fetch accepts redirect this cycle.
REQ-010 redirect_valid  output  1  redirect request to fetch.
REQ-011 redirect_pc  output  32 (word_t)  redirect target; stable while redirect_valid=1.
REQ-012 s2_stall  output  1  hold stage 2; no new s2 instruction consumed.
REQ-013 kill_younger  output  1  one-cycle pulse: squash s1 contents.
REQ-014 misaligned  output  1  one-cycle pulse: taken target with target[1:0]!=0.
REQ-015 stat_resolved  output  32  resolved branch/jump count (see Configuration).
REQ-016 stat_taken  output  32  taken redirect count (see Configuration).

Function
REQ-017 Taken condition: s2_valid & !s2_stall & !flush & (s2_is_jump | (s2_is_branch & cmp_result)); evaluated combinationally, captured on clock edge.
REQ-018 States: IDLE, PENDING; reset state IDLE.
REQ-019 IDLE, taken, s2_target[1:0]==0: capture s2_target into redirect_pc register, go PENDING, kill_younger=1 in the following cycle (first PENDING cycle).
REQ-020 IDLE, taken, s2_target[1:0]!=0: stay IDLE, no redirect, misaligned=1 for exactly the next cycle.
REQ-021 IDLE, not taken (branch with cmp_result=0, or non-branch): stay IDLE, no outputs asserted; zero added latency.
REQ-022 redirect_valid = (state==PENDING) & !flush; redirect latency = 1 cycle after the capturing edge.
REQ-023 PENDING: redirect_valid, redirect_pc held until handshake (redirect_valid & redirect_ready); on handshake go IDLE next cycle.
REQ-024 Handshake on first PENDING cycle permitted: PENDING lasts exactly one cycle.
REQ-025 s2_stall = (state==PENDING); combinational, deasserts in the cycle after handshake.
REQ-026 flush in PENDING: go IDLE next cycle, redirect discarded; flush overrides simultaneous redirect_ready (no handshake counted).
REQ-027 flush in IDLE: no capture that cycle even if taken condition inputs are true.
REQ-028 kill_younger and misaligned never asserted in the same cycle; neither asserted while flush=1 (gated combinationally).
REQ-029 redirect_pc retains last captured value in IDLE; contents don't-care when redirect_valid=0.

Reset
REQ-030 On rst_n=0 at a clock edge: state=IDLE; redirect_pc=0; kill_younger, misaligned pulses cleared; stat counters=0.
REQ-031 Reset mid-PENDING abandons redirect; redirect_valid=0 and s2_stall=0 in the cycle after the reset edge.
REQ-032 Reset has priority over all other inputs including flush and redirect_ready.

Configuration
REQ-033 Macro LETC_BRANCH_STATS_EN: when defined, stat_resolved increments on every accepted s2 branch/jump (s2_valid & !s2_stall & !flush & (s2_is_branch|s2_is_jump)), stat_taken increments on every completed redirect handshake; both wrap modulo 2^32.
REQ-034 Without LETC_BRANCH_STATS_EN: ports remain present, stat_resolved and stat_taken tied to 0, no counter flops instantiated.

Verification
REQ-035 BEQ taken, s2_target=0x0000_1000, redirect_ready=1 continuously -> next cycle redirect_valid=1, redirect_pc=0x1000, kill_younger=1, s2_stall=1; cycle after: IDLE, all low.
REQ-036 JAL target=0x2000, redirect_ready=0 for 3 cycles then 1 -> redirect_valid and s2_stall high 4 cycles, redirect_pc=0x2000 constant, kill_younger only in first.
REQ-037 BNE with cmp_result=0 -> no redirect_valid, no stall, stat_resolved+1, stat_taken unchanged (stats build).
REQ-038 Taken branch target=0x0000_1002 -> misaligned=1 one cycle, redirect_valid stays 0, state IDLE.
REQ-039 PENDING with flush=1 and redirect_ready=1 same cycle -> redirect_valid=0 that cycle, IDLE next, stat_taken unchanged.
REQ-040 rst_n=0 during PENDING -> next cycle redirect_valid=0, s2_stall=0, redirect_pc=0, stats=0.
